display_mux: RTL

//  Time-multiplexed N-digit 7-segment driver; successor of the single-digit hex decoder.

---
 rtl/display_pkg.sv | 47 ++++
 rtl/seg7_hex_dec.sv | 13 +
 rtl/display_mux.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Glyph table and nibble decode shared by the display driver.
// All glyphs are active-low, bit order g..a.
package display_pkg;

    localparam logic [6:0] SEG_0       = 7'h40;
    localparam logic [6:0] SEG_1       = 7'h79;
    localparam logic [6:0] SEG_2       = 7'h24;
    localparam logic [6:0] SEG_3       = 7'h30;
    localparam logic [6:0] SEG_4       = 7'h19;
    localparam logic [6:0] SEG_5       = 7'h12;
    localparam logic [6:0] SEG_6       = 7'h02;
    localparam logic [6:0] SEG_7       = 7'h78;
    localparam logic [6:0] SEG_8       = 7'h00;
    localparam logic [6:0] SEG_9       = 7'h18;
    localparam logic [6:0] SEG_A       = 7'h08;
    localparam logic [6:0] SEG_B       = 7'h03;
    localparam logic [6:0] SEG_C       = 7'h46;
    localparam logic [6:0] SEG_D       = 7'h21;
    localparam logic [6:0] SEG_E       = 7'h06;
    localparam logic [6:0] SEG_F       = 7'h0E;
    localparam logic [6:0] SEG_MENOS   = 7'h3F;
    localparam logic [6:0] SEG_APAGADO = 7'h7F;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = SEG_0;
            4'h1:    g = SEG_1;
            4'h2:    g = SEG_2;
            4'h3:    g = SEG_3;
            4'h4:    g = SEG_4;
            4'h5:    g = SEG_5;
            4'h6:    g = SEG_6;
            4'h7:    g = SEG_7;
            4'h8:    g = SEG_8;
            4'h9:    g = SEG_9;
            4'hA:    g = SEG_A;
            4'hB:    g = SEG_B;
            4'hC:    g = SEG_C;
            4'hD:    g = SEG_D;
            4'hE:    g = SEG_E;
            default: g = SEG_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Single nibble to active-low 7-segment glyph.
// Purely combinational.
module seg7_hex_dec
    import display_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    // table lookup through the shared glyph function
    assign o_seg = hex_glyph(i_nib);

endmodule

// File: rtl/display_mux.sv
// Time-multiplexed N-digit hex display driver with sign,
// leading-zero blanking, blink and overflow dashes.
module display_mux
    import display_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int DATA_W    = 16,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 12500000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [DATA_W-1:0]   valor,
    input  logic                sinal,
    input  logic                blank_lz,
    input  logic                blink_en,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] an,
    output logic                ovf
);

    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    // magnitude is DATA_W+1 bits so the most negative value fits
    localparam int NIB_MAG = (DATA_W + 4) / 4;
    localparam int NIB_T   = (NIB_MAG > N_DIGITS) ? NIB_MAG : N_DIGITS;
    localparam int MAG_W   = NIB_T * 4;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_DIGITS - 1);

    logic [DATA_W-1:0]   r_valor;
    logic                r_sinal;
    logic                r_blank_lz;
    logic [IDX_W-1:0]    r_idx;
    logic [SCAN_W-1:0]   r_scan;
    logic [BLINK_W-1:0]  r_blink;
    logic                r_phase;
    logic [6:0]          r_seg;
    logic [N_DIGITS-1:0] r_an;

    logic                w_neg;
    logic [DATA_W:0]     w_mag;
    logic [MAG_W-1:0]    w_magx;
    int                  w_avail;
    int                  w_msd;
    int                  w_k;
    logic                w_ovf;
    logic [3:0]          w_nib;
    logic [6:0]          w_hex;
    logic [6:0]          w_seg_nxt;
    logic [N_DIGITS-1:0] w_an_nxt;

    // latch value and display modes on load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valor    <= '0;
            r_sinal    <= 1'b0;
            r_blank_lz <= 1'b0;
        end else if (load) begin
            r_valor    <= valor;
            r_sinal    <= sinal;
            r_blank_lz <= blank_lz;
        end
    end

    assign w_neg   = r_sinal & r_valor[DATA_W-1];
    assign w_mag   = w_neg ? ({1'b0, ~r_valor} + {{DATA_W{1'b0}}, 1'b1})
                           : {1'b0, r_valor};
    assign w_avail = w_neg ? (N_DIGITS - 1) : N_DIGITS;
    assign w_k     = int'(r_idx);

    // zero-extend magnitude to a whole number of nibbles
    always_comb begin
        w_magx           = '0;
        w_magx[DATA_W:0] = w_mag;
    end

    // most significant nonzero nibble and fit check
    always_comb begin
        w_msd = 0;
        w_ovf = 1'b0;
        for (int k = 0; k < NIB_T; k++) begin
            if (w_magx[4*k +: 4] != 4'h0) begin
                w_msd = k;
                if (k >= w_avail) w_ovf = 1'b1;
            end
        end
    end

    // nibble and anode pattern for the digit being scanned
    always_comb begin
        w_nib    = 4'h0;
        w_an_nxt = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (w_k == k) begin
                w_nib       = w_magx[4*k +: 4];
                w_an_nxt[k] = 1'b0;
            end
        end
    end

    seg7_hex_dec u_dec (
        .i_nib (w_nib),
        .o_seg (w_hex)
    );

    // pick glyph: dashes on overflow, else digit, sign or blank
    always_comb begin
        w_seg_nxt = SEG_APAGADO;
        if (w_ovf) begin
            w_seg_nxt = SEG_MENOS;
        end else if (!r_blank_lz) begin
            if (w_k < w_avail)
                w_seg_nxt = w_hex;
            else if (w_neg && w_k == N_DIGITS - 1)
                w_seg_nxt = SEG_MENOS;
        end else begin
            if (w_k <= w_msd || w_k == 0)
                w_seg_nxt = w_hex;
            else if (w_neg && w_k == w_msd + 1)
                w_seg_nxt = SEG_MENOS;
        end
    end

    // scan prescaler and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan <= '0;
            r_idx  <= '0;
        end else if (r_scan == SCAN_LAST) begin
            r_scan <= '0;
            if (N_DIGITS == 1 || r_idx == IDX_LAST)
                r_idx <= '0;
            else
                r_idx <= r_idx + IDX_W'(1);
        end else begin
            r_scan <= r_scan + SCAN_W'(1);
        end
    end

    // free-running blink phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink <= '0;
            r_phase <= 1'b0;
        end else if (r_blink == BLINK_LAST) begin
            r_blink <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_blink <= r_blink + BLINK_W'(1);
        end
    end

    // registered pin drive, dark during blink-off phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_APAGADO;
            r_an  <= '1;
        end else if (blink_en && r_phase) begin
            r_seg <= SEG_APAGADO;
            r_an  <= '1;
        end else begin
            r_seg <= w_seg_nxt;
            r_an  <= w_an_nxt;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;
    assign ovf = w_ovf;

endmodule
